csa_tree_pipe: RTL and testbench
================================

# csa_tree_pipe

Parametrised, pipelined carry-save reduction tree for the FPU multiplier datapath. It compresses N partial products of width W into a redundant (t, s) pair, and a resolved sum, using 4:2 compressor levels built from two 3:2 rows. Register stages are inserted every LEVELS_PER_STAGE levels, with a valid/ready handshake, global stall and flush. It sits between the partial-product generator and the final carry-propagate/rounding stage.

## Interface
- W, 116: partial and result width; all arithmetic is mod 2^W.
- N, 58: number of partial products; must be at least 1.
- LEVELS_PER_STAGE, 2: 4:2 levels per pipeline register stage; must be at least 1.
- clk  in  1  clock; all registers update on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  partials present.
- in_ready  out  1  tree accepts this cycle.
- partials  in  N*W  partial j at bits [j*W +: W].
- flush  in  1  synchronous discard of all in-flight data.
- out_valid  out  1  t/s/sum valid.
- out_ready  in  1  consumer accepts.
- t  out  W  carry vector of the redundant result; bit 0 always 0.
- s  out  W  sum vector of the redundant result.
- sum  out  W  (t + s) mod 2^W, combinational from the t/s registers.
- busy  out  1  any stage holds valid data.

## Operation
- Pad: NP = max(4, 2^clog2(N)). Partials j ≥ N are zero.
- Level count: L = clog2(NP) − 1. Examples: N=58 gives NP=64, L=5; N=3 gives L=1.
- Stage count: S = ceil(L / LEVELS_PER_STAGE).
- Level 1, per group of four partials (p0..p3, ascending index):
  - 3:2 row on p0, p1, p2 gives bitwise sum u and carry c, with c shifted left by 1.
  - 3:2 row on u, c, p3 gives s, and t shifted left by 1.
- Levels 2..L: each node combines the lower-index child (ta, sa) and the upper-index child (tb, sb) using the same two rows on (ta, sa, tb), then with sb.
- Width rule: every carry out of bit W−1 is dropped. Invariant: t + s ≡ Σ partials (mod 2^W).
- Stage k registers the outputs of levels (k−1)·LEVELS_PER_STAGE+1 to k·LEVELS_PER_STAGE. Each stage register carries a valid bit. The last stage drives t and s.
- adv = !out_valid || out_ready. All stages shift only when adv = 1 (global stall; bubbles are not collapsed).
- in_ready = adv. A transfer occurs when in_valid && in_ready.
- flush = 1: all stage valid bits clear at the next edge, the input is not captured, and data registers may keep stale values. Flush overrides a simultaneous input transfer and output hand-off; out_valid is 0 the next cycle.
- busy = OR of all stage valid bits.

## Timing
- Reset values: out_valid=0, busy=0, and all stage data registers, t, s, sum = 0. in_ready is 1 while reset is deasserted and the pipe is empty.
- Asserting rst mid-operation discards all in-flight transactions immediately and asynchronously.
- Latency: an input accepted at edge e appears with out_valid=1 after edge e+S−1, i.e. S cycles from acceptance to output available. N=58 with default LEVELS_PER_STAGE gives S=3.
- Throughput: one result per cycle while out_ready=1.
- Stall: while out_valid && !out_ready, t, s and sum are held stable, no stage changes, and in_ready=0.
- Order is preserved, with no loss or duplication.
- Idle cycles propagate as bubbles, with valid=0 in the corresponding stage.

## Test plan
- Reset, then 58 partials each = 1 with W=116 and a single in_valid pulse -> out_valid rises 3 cycles later; sum=58; t+s=58; t[0]=0; busy falls once the result is taken.
- 10 back-to-back random vectors with out_ready=1 -> results on 10 consecutive cycles, in order. Each must match a bit-exact model of t and s, and sum = Σ mod 2^116.
- 4 transactions in flight, then out_ready=0 for 5 cycles -> in_ready=0 and outputs held stable. After release, all 4 results emerge once each, in order.
- All 58 partials = 2^116−1 -> sum = 2^116−58.
- Two cases on in-flight data:
  - flush asserted together with in_valid while 2 transactions are in flight -> no out_valid afterwards.
  - rst pulsed mid-flight -> outputs return to 0 immediately.
- Parameter sweeps:
  - N=3, LEVELS_PER_STAGE=1, W=8, partials 255, 1, 2 -> latency 1, sum=2.
  - N=5, LEVELS_PER_STAGE=1 -> S=2.

Source files
------------

// File: rtl/csa_tree_pipe.sv
// csa_tree_pipe: pipelined 4:2 carry-save reduction of N partial products into a
// redundant (t, s) pair plus resolved sum, registered every LEVELS_PER_STAGE levels.
module csa_tree_pipe #(
    parameter int unsigned W                = 116,
    parameter int unsigned N                = 58,
    parameter int unsigned LEVELS_PER_STAGE = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] partials,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   t,
    output logic [W-1:0]   s,
    output logic [W-1:0]   sum,
    output logic           busy
);
    localparam int unsigned NP = (N <= 4) ? 4 : (1 << $clog2(N));
    localparam int unsigned L  = $clog2(NP) - 1;

    // Level l outputs NP>>l words at offset NP - (NP>>(l-1)), laid out t0,s0,t1,s1,...
    logic [W-1:0] lvl_d [NP-2];
    logic [L:1]   lvl_v;
    logic [L:1]   stage_v;
    logic         adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar l = 1; l <= L; l++) begin : lvl
        localparam int unsigned NODES    = NP >> (l + 1);
        localparam int unsigned OUT_OFF  = NP - (NP >> (l - 1));
        localparam bit          BOUNDARY = ((l % LEVELS_PER_STAGE) == 0) || (l == L);

        logic [W-1:0] din  [4*NODES];
        logic [W-1:0] dout [2*NODES];
        logic         vin;

        if (l == 1) begin : src_in
            for (genvar j = 0; j < 4*NODES; j++) begin : pad
                if (j < N) begin : live
                    assign din[j] = partials[j*W +: W];
                end else begin : zero
                    assign din[j] = '0;
                end
            end
            assign vin = in_valid;
        end else begin : src_lvl
            localparam int unsigned IN_OFF = NP - (NP >> (l - 2));
            for (genvar j = 0; j < 4*NODES; j++) begin : tap
                assign din[j] = lvl_d[IN_OFF + j];
            end
            assign vin = lvl_v[l-1];
        end

        // Operands per node: (a, b, c, d) = (ta, sa, tb, sb), or p0..p3 at level 1
        for (genvar i = 0; i < NODES; i++) begin : node
            logic [W-1:0] u, c;
            assign u = din[4*i] ^ din[4*i+1] ^ din[4*i+2];
            assign c = ((din[4*i] & din[4*i+1]) | (din[4*i] & din[4*i+2]) |
                        (din[4*i+1] & din[4*i+2])) << 1;
            assign dout[2*i+1] = u ^ c ^ din[4*i+3];
            assign dout[2*i]   = ((u & c) | (u & din[4*i+3]) | (c & din[4*i+3])) << 1;
        end

        if (BOUNDARY) begin : reg_stage
            logic [W-1:0] q [2*NODES];
            logic         qv;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    qv <= 1'b0;
                    for (int unsigned i = 0; i < 2*NODES; i++) q[i] <= '0;
                end else if (flush) begin
                    qv <= 1'b0;
                end else if (adv) begin
                    qv <= vin;
                    if (vin) q <= dout;
                end
            end

            for (genvar i = 0; i < 2*NODES; i++) begin : drv
                assign lvl_d[OUT_OFF + i] = q[i];
            end
            assign lvl_v[l]   = qv;
            assign stage_v[l] = qv;
        end else begin : comb_stage
            for (genvar i = 0; i < 2*NODES; i++) begin : drv
                assign lvl_d[OUT_OFF + i] = dout[i];
            end
            assign lvl_v[l]   = vin;
            assign stage_v[l] = 1'b0;
        end
    end

    assign t         = lvl_d[NP-4];
    assign s         = lvl_d[NP-3];
    assign out_valid = lvl_v[L];
    assign sum       = t + s;
    assign busy      = |stage_v;

endmodule

// File: tb/tb_csa_tree_pipe.sv
// tb_csa_tree_pipe: directed checks of csa_tree_pipe at the default size plus two
// small configurations (N=3 and N=5, one level per stage, W=8).
`timescale 1ns/1ps
module tb_csa_tree_pipe;
    localparam int W    = 116;
    localparam int N    = 58;
    localparam int NPAD = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [N*W-1:0] partials;
    logic [W-1:0]   t, s, sum;

    csa_tree_pipe #(.W(W), .N(N), .LEVELS_PER_STAGE(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .partials(partials), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .t(t), .s(s), .sum(sum), .busy(busy)
    );

    logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_busy;
    logic [23:0] b_partials;
    logic [7:0]  b_t, b_s, b_sum;

    csa_tree_pipe #(.W(8), .N(3), .LEVELS_PER_STAGE(1)) dut_n3 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .partials(b_partials), .flush(b_flush), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .t(b_t), .s(b_s), .sum(b_sum), .busy(b_busy)
    );

    logic        c_in_valid, c_in_ready, c_flush, c_out_valid, c_out_ready, c_busy;
    logic [39:0] c_partials;
    logic [7:0]  c_t, c_s, c_sum;

    csa_tree_pipe #(.W(8), .N(5), .LEVELS_PER_STAGE(1)) dut_n5 (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .partials(c_partials), .flush(c_flush), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .t(c_t), .s(c_s), .sum(c_sum), .busy(c_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] maj(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [W-1:0] ref_sum(input logic [N*W-1:0] p);
        logic [W-1:0] acc;
        acc = '0;
        for (int j = 0; j < N; j++) acc = acc + p[j*W +: W];
        return acc;
    endfunction

    // Reduces in place: each pass turns groups of four words into (t, s) pairs
    function automatic void ref_tree(input logic [N*W-1:0] p, output logic [W-1:0] rt,
                                     output logic [W-1:0] rs);
        logic [W-1:0] w [NPAD];
        logic [W-1:0] u, c, x, y;
        int cnt;
        for (int j = 0; j < NPAD; j++) begin
            if (j < N) w[j] = p[j*W +: W];
            else       w[j] = '0;
        end
        cnt = NPAD;
        while (cnt > 2) begin
            for (int i = 0; i < cnt / 4; i++) begin
                u = w[4*i] ^ w[4*i+1] ^ w[4*i+2];
                c = maj(w[4*i], w[4*i+1], w[4*i+2]) << 1;
                x = u ^ c ^ w[4*i+3];
                y = maj(u, c, w[4*i+3]) << 1;
                w[2*i]   = y;
                w[2*i+1] = x;
            end
            cnt = cnt / 2;
        end
        rt = w[0];
        rs = w[1];
    endfunction

    function automatic logic [N*W-1:0] rand_vec();
        logic [N*W-1:0] v;
        logic [127:0]   r;
        for (int j = 0; j < N; j++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            v[j*W +: W] = r[W-1:0];
        end
        return v;
    endfunction

    logic [N*W-1:0] vec  [16];
    logic [W-1:0]   et   [16];
    logic [W-1:0]   es   [16];
    logic [W-1:0]   esum [16];
    logic [W-1:0]   ts, mx, one, mt, ms;
    int             sb_q [$];
    int             n_out;
    bit             took;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle with scoreboard bookkeeping for the transfers about to happen
    task automatic step(input int idx, output bit accepted);
        int k;
        accepted = 1'b0;
        if (in_valid && in_ready) begin
            sb_q.push_back(idx);
            accepted = 1'b1;
        end
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("spurious_out", 128'(out_valid), 128'd0);
            end else begin
                k = sb_q.pop_front();
                n_out++;
                check($sformatf("sb_t%0d", k), 128'(t), 128'(et[k]));
                check($sformatf("sb_s%0d", k), 128'(s), 128'(es[k]));
                check($sformatf("sb_sum%0d", k), 128'(sum), 128'(esum[k]));
            end
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; partials = '0;
        b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1; b_partials = '0;
        c_in_valid = 1'b0; c_flush = 1'b0; c_out_ready = 1'b1; c_partials = '0;
        for (int i = 0; i < 16; i++) begin
            vec[i] = rand_vec();
            ref_tree(vec[i], et[i], es[i]);
            esum[i] = ref_sum(vec[i]);
        end
        repeat (2) tick();
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_t", 128'(t), 128'd0);
        check("rst_s", 128'(s), 128'd0);
        check("rst_sum", 128'(sum), 128'd0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", 128'(in_ready), 128'd1);

        // 58 partials of value 1, single pulse
        one = 1;
        for (int j = 0; j < N; j++) partials[j*W +: W] = one;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat_e0", 128'(out_valid), 128'd0);
        tick();
        check("lat_e1", 128'(out_valid), 128'd0);
        tick();
        check("lat_e2", 128'(out_valid), 128'd1);
        check("ones_sum", 128'(sum), 128'd58);
        ts = t + s;
        check("ones_ts", 128'(ts), 128'd58);
        check("ones_t0", 128'(t[0]), 128'd0);
        tick();
        check("ones_taken", 128'(out_valid), 128'd0);
        check("ones_busy", 128'(busy), 128'd0);

        // Ten back-to-back vectors, results expected on ten consecutive cycles
        for (int c = 0; c < 13; c++) begin
            in_valid = (c < 10);
            if (c < 10) partials = vec[c];
            tick();
            if (c >= 2 && c <= 11) begin
                check($sformatf("b2b_valid%0d", c), 128'(out_valid), 128'd1);
                check($sformatf("b2b_t%0d", c - 2), 128'(t), 128'(et[c-2]));
                check($sformatf("b2b_s%0d", c - 2), 128'(s), 128'(es[c-2]));
                check($sformatf("b2b_sum%0d", c - 2), 128'(sum), 128'(esum[c-2]));
            end else begin
                check($sformatf("b2b_valid%0d", c), 128'(out_valid), 128'd0);
            end
        end
        in_valid = 1'b0;

        // Stall with the pipe full and a fifth vector waiting at the input
        n_out = 0;
        sb_q.delete();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            partials = vec[10+k];
            step(10 + k, took);
        end
        partials = vec[14];
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("stall_in_ready", 128'(in_ready), 128'd0);
            check("stall_valid", 128'(out_valid), 128'd1);
            check("stall_t", 128'(t), 128'(et[11]));
            check("stall_s", 128'(s), 128'(es[11]));
            check("stall_sum", 128'(sum), 128'(esum[11]));
            step(14, took);
        end
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 20 && n_out < 5; k++) begin
            step(14, took);
            if (took) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check("stall_count", 128'(n_out), 128'd5);
        check("stall_left", 128'(sb_q.size()), 128'd0);
        check("stall_busy", 128'(busy), 128'd0);

        // All partials at the maximum value
        partials = '1;
        ref_tree(partials, mt, ms);
        mx = '0;
        mx = mx - 116'd58;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("max_valid", 128'(out_valid), 128'd1);
        check("max_sum", 128'(sum), 128'(mx));
        check("max_t", 128'(t), 128'(mt));
        check("max_s", 128'(s), 128'(ms));
        tick();

        // Flush together with a new input while two transactions are in flight
        partials = vec[0];
        in_valid = 1'b1;
        tick();
        partials = vec[1];
        tick();
        partials = vec[2];
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_busy", 128'(busy), 128'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("flush_valid%0d", k), 128'(out_valid), 128'd0);
            tick();
        end

        // Asynchronous reset mid-flight
        for (int k = 3; k < 6; k++) begin
            partials = vec[k];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("rstmid_pre_valid", 128'(out_valid), 128'd1);
        rst = 1'b1;
        #1;
        check("rstmid_valid", 128'(out_valid), 128'd0);
        check("rstmid_busy", 128'(busy), 128'd0);
        check("rstmid_t", 128'(t), 128'd0);
        check("rstmid_s", 128'(s), 128'd0);
        check("rstmid_sum", 128'(sum), 128'd0);
        tick();
        rst = 1'b0;
        tick();

        // N=3, one level per stage: latency 1
        b_partials = {8'd2, 8'd1, 8'd255};
        b_in_valid = 1'b1;
        check("n3_pre_valid", 128'(b_out_valid), 128'd0);
        tick();
        b_in_valid = 1'b0;
        check("n3_valid", 128'(b_out_valid), 128'd1);
        check("n3_sum", 128'(b_sum), 128'd2);
        check("n3_t", 128'(b_t), 128'h08);
        check("n3_s", 128'(b_s), 128'hfa);
        tick();
        check("n3_taken", 128'(b_out_valid), 128'd0);

        // N=5, one level per stage: two stages
        c_partials = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        c_in_valid = 1'b1;
        tick();
        c_in_valid = 1'b0;
        check("n5_e0_valid", 128'(c_out_valid), 128'd0);
        check("n5_e0_busy", 128'(c_busy), 128'd1);
        tick();
        check("n5_e1_valid", 128'(c_out_valid), 128'd1);
        check("n5_sum", 128'(c_sum), 128'd15);
        check("n5_t", 128'(c_t), 128'd0);
        check("n5_s", 128'(c_s), 128'd15);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
